// File: rtl/seg7_capture_pkg.sv
// Shared 7-segment definitions: bit order, the legal pattern table and capture FSM encodings.
// The display decoder imports the same table so both ends agree on every glyph.
package seg7_capture_pkg;

  // Segment bit positions within the 7-bit bus (1 = lit)
  localparam int SEG_A = 0;  // top
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;  // bottom
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;  // middle

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A_HEX = 7'h77;
  localparam logic [6:0] SEG_B_HEX = 7'h7C;
  localparam logic [6:0] SEG_C_HEX = 7'h39;
  localparam logic [6:0] SEG_D_HEX = 7'h5E;
  localparam logic [6:0] SEG_E_HEX = 7'h79;
  localparam logic [6:0] SEG_F_HEX = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WAIT_CHANGE = 2'd1;
  localparam logic [1:0] SETTLE      = 2'd2;
  localparam logic [1:0] OFFER       = 2'd3;

endpackage

// File: rtl/seg7_lookup.sv
// Combinational reverse lookup: segment pattern -> hex nibble plus legal/blank classification.
// Anything neither legal nor blank is an illegal glyph.
module seg7_lookup
  import seg7_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    nibble = 4'h0;
    legal  = 1'b1;
    blank  = 1'b0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A_HEX: nibble = 4'hA;
      SEG_B_HEX: nibble = 4'hB;
      SEG_C_HEX: nibble = 4'hC;
      SEG_D_HEX: nibble = 4'hD;
      SEG_E_HEX: nibble = 4'hE;
      SEG_F_HEX: nibble = 4'hF;
      default: begin
        legal = 1'b0;
        blank = (pattern == SEG_BLANK);
      end
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Samples a 7-segment bus, debounces it, recovers the hex nibble and offers it over valid/ready.
// Each distinct stable pattern is reported once; illegal glyphs pulse code_err and bump err_count.
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,  // legal range 2..15 (cnt is 4 bits)
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [6:0]       segments,
  output logic [3:0]       value,
  output logic             value_valid,
  input  logic             value_ready,
  output logic             code_err,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);

  localparam logic [3:0] LAST_CNT = 4'(STABLE_CYCLES - 1);

  logic [6:0] sync1, sync2, sample;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [3:0] lk_nibble;
  logic       lk_legal, lk_blank;

  seg7_lookup u_lookup (
    .pattern (sample),
    .nibble  (lk_nibble),
    .legal   (lk_legal),
    .blank   (lk_blank)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= segments;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sample      <= '0;
      cnt         <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      code_err    <= 1'b0;
      err_count   <= '0;
    end else begin
      code_err <= 1'b0;
      if (!en) begin
        state       <= IDLE;
        value_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // Whatever is already displayed becomes the reference, so it is not reported.
            sample <= sync2;
            state  <= WAIT_CHANGE;
          end
          WAIT_CHANGE: begin
            if (sync2 != sample) begin
              sample <= sync2;
              cnt    <= 4'd1;
              state  <= SETTLE;
            end
          end
          SETTLE: begin
            if (sync2 != sample) begin
              sample <= sync2;
              cnt    <= 4'd1;
            end else if (cnt == LAST_CNT) begin
              cnt <= cnt + 4'd1;
              if (lk_legal) begin
                value       <= lk_nibble;
                value_valid <= 1'b1;
                state       <= OFFER;
              end else begin
                if (!lk_blank) begin
                  code_err <= 1'b1;
                  if (err_count != '1) err_count <= err_count + ERR_W'(1);
                end
                state <= WAIT_CHANGE;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          OFFER: begin
            // sample keeps the offered glyph so a change-and-revert while stalled is not re-reported
            if (value_ready) begin
              value_valid <= 1'b0;
              state       <= WAIT_CHANGE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state == SETTLE) || (state == OFFER);

endmodule
